// File: rtl/lte_dl_pow_cfg_ctrl.sv
// Per-antenna DL gain controller: targets are staged while idle, then applied to the
// active gains on frame heads, either at once or ramped by a bounded step per frame.
module lte_dl_pow_cfg_ctrl #(
  parameter logic [31:0] DEF_GAIN = 32'h7FFF_0000
) (
  input  logic        clk,
  input  logic        asy_rst,
  input  logic        i_cfg_wr,
  input  logic [2:0]  i_cfg_addr,
  input  logic [31:0] i_cfg_data,
  output logic        o_cfg_ready,
  output logic        o_wr_drop,
  input  logic        i_commit,
  input  logic [14:0] i_ramp_step,
  input  logic        i_fram_hd,
  output logic [31:0] o_ant0_pow,
  output logic [31:0] o_ant1_pow,
  output logic [31:0] o_ant2_pow,
  output logic [31:0] o_ant3_pow,
  output logic [31:0] o_ant4_pow,
  output logic [31:0] o_ant5_pow,
  output logic [31:0] o_ant6_pow,
  output logic [31:0] o_ant7_pow,
  output logic        o_busy,
  output logic        o_upd_pulse,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, ARMED, RAMP} state_t;

  state_t            state_q, state_d;
  logic [14:0]       step_q, step_d;
  logic              wr_drop_q, upd_q, done_q;
  logic              wr_drop_d, upd_d, done_d;
  logic              apply;
  logic              wr_en;
  logic [7:0][31:0]  act_all;
  logic [7:0][31:0]  act_nx;
  logic [7:0]        ant_eq;
  logic [7:0]        ant_chg;

  // Diff is taken in 17-bit signed so a full-scale swing cannot wrap; the stepped
  // value always lies between c and t, so it fits back into 16 bits.
  function automatic logic [15:0] step_comp(input logic [15:0] c, input logic [15:0] t,
                                            input logic [14:0] s);
    logic signed [16:0] diff;
    logic [16:0]        mag;
    diff = $signed({t[15], t}) - $signed({c[15], c});
    mag  = diff[16] ? 17'(-diff) : 17'(diff);
    if (s == 15'd0 || mag <= {2'b00, s}) return t;
    else if (diff[16])                    return c - {1'b0, s};
    else                                  return c + {1'b0, s};
  endfunction

  assign wr_en = i_cfg_wr && (state_q == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_ant
      logic [31:0] tgt_q;
      logic [31:0] act_q;

      assign act_nx[gi]  = {step_comp(act_q[31:16], tgt_q[31:16], step_q),
                            step_comp(act_q[15:0],  tgt_q[15:0],  step_q)};
      assign ant_eq[gi]  = (act_nx[gi] == tgt_q);
      assign ant_chg[gi] = (act_nx[gi] != act_q);
      assign act_all[gi] = act_q;

      always_ff @(posedge clk) begin
        if (asy_rst) begin
          tgt_q <= DEF_GAIN;
          act_q <= DEF_GAIN;
        end else begin
          if (wr_en && i_cfg_addr == 3'(gi)) tgt_q <= i_cfg_data;
          if (apply)                         act_q <= act_nx[gi];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    apply     = 1'b0;
    wr_drop_d = i_cfg_wr && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (i_commit) begin
          step_d  = i_ramp_step;
          state_d = ARMED;
        end
      end
      ARMED, RAMP: begin
        if (i_fram_hd) begin
          apply   = 1'b1;
          state_d = (&ant_eq) ? IDLE : RAMP;
        end
      end
      default: state_d = IDLE;
    endcase
    upd_d  = apply && (|ant_chg);
    done_d = apply && (&ant_eq);
  end

  always_ff @(posedge clk) begin
    if (asy_rst) begin
      state_q   <= IDLE;
      step_q    <= 15'd0;
      wr_drop_q <= 1'b0;
      upd_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      wr_drop_q <= wr_drop_d;
      upd_q     <= upd_d;
      done_q    <= done_d;
    end
  end

  assign o_cfg_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_wr_drop   = wr_drop_q;
  assign o_upd_pulse = upd_q;
  assign o_done      = done_q;
  assign o_ant0_pow  = act_all[0];
  assign o_ant1_pow  = act_all[1];
  assign o_ant2_pow  = act_all[2];
  assign o_ant3_pow  = act_all[3];
  assign o_ant4_pow  = act_all[4];
  assign o_ant5_pow  = act_all[5];
  assign o_ant6_pow  = act_all[6];
  assign o_ant7_pow  = act_all[7];

endmodule

// File: doc/lte_dl_pow_cfg_ctrl.md
LTE_DL_POW_CFG_CTRL -- requirements
Module: lte_dl_pow_cfg_ctrl

Interface
REQ-001 Parameter: DEF_GAIN, 32'h7FFF_0000, reset gain for every antenna ({I[31:16]=+0x7FFF, Q[15:0]=0}, approximately unity).
REQ-002 The module SHALL have one clock and one synchronous, active-high reset; no other clock or reset ports.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 asy_rst  in  1  synchronous active-high reset, sampled on rising clk.
REQ-005 i_cfg_wr  in  1  target-gain write strobe.
REQ-006 i_cfg_addr  in  3  antenna index 0..7 for the write.
REQ-007 i_cfg_data  in  32  target gain {I[31:16], Q[15:0]}, two's complement per component.
REQ-008 o_cfg_ready  out  1  write accepted when high.
REQ-009 o_wr_drop  out  1  one-cycle pulse: write strobe arrived while o_cfg_ready low.
REQ-010 i_commit  in  1  single-cycle request to apply the targets.
REQ-011 i_ramp_step  in  15  unsigned max change per component per frame; 0 means immediate.
REQ-012 i_fram_hd  in  1  frame-head pulse from the DL timing chain.
REQ-013 o_ant0_pow .. o_ant7_pow  out  32 each  active per-antenna gains that feed the DL power multiplier.
REQ-014 o_busy  out  1  high in ARMED or RAMP.
REQ-015 o_upd_pulse  out  1  one-cycle pulse: at least one active gain changed this edge.
REQ-016 o_done  out  1  one-cycle pulse: commit fully applied.

Function
REQ-017 The module SHALL hold 8 target registers tgt[n] and 8 active registers act[n]; o_antN_pow SHALL equal act[N] and be driven directly from flops.
REQ-018 States: IDLE, ARMED, RAMP; o_cfg_ready SHALL be 1 only in IDLE.
REQ-019 In IDLE, i_cfg_wr SHALL write tgt[i_cfg_addr] <= i_cfg_data at that edge; act is unaffected.
REQ-020 In ARMED or RAMP, i_cfg_wr SHALL be discarded (tgt unchanged) and o_wr_drop SHALL pulse on the following cycle.
REQ-021 IDLE + i_commit SHALL latch i_ramp_step into step_q and go to ARMED; i_fram_hd on that same edge SHALL NOT apply anything.
REQ-022 i_commit in ARMED or RAMP SHALL be ignored.
REQ-023 ARMED/RAMP + i_fram_hd: each 16-bit component c of every act[n] SHALL move to its target t: if step_q==0 or |t-c|<=step_q then c<=t, else c<=c+step_q toward t; the difference SHALL be computed in 17-bit signed and never wrap.
REQ-024 After the update in REQ-023, the state SHALL go to IDLE if every act equals tgt, otherwise to RAMP; IDLE is reached with o_done pulsing in the cycle after that edge.
REQ-025 The gain application in REQ-023 SHALL occur on the edge where i_fram_hd is sampled high; the new values and o_upd_pulse SHALL be visible in the following cycle, with zero added latency.
REQ-026 o_upd_pulse SHALL be asserted only if some act value changed; a commit with tgt==act SHALL give o_done at the next frame head without o_upd_pulse.
REQ-027 i_fram_hd in IDLE SHALL have no effect.
REQ-028 Ramp duration SHALL be ceil(max component distance / step_q) frame heads (1 when step_q==0).

Reset
REQ-029 On asy_rst: all tgt and act = DEF_GAIN, state = IDLE, step_q = 0, o_cfg_ready = 1, o_busy/o_upd_pulse/o_done/o_wr_drop = 0.
REQ-030 Reset mid-RAMP SHALL abandon the ramp; the partially ramped act values SHALL revert to DEF_GAIN and no o_done SHALL pulse.

Verification
REQ-031 Immediate: write ant3=32'h4000_2000, commit with step 0, frame head -> next cycle o_ant3_pow=32'h4000_2000, other antennas 32'h7FFF_0000, o_upd_pulse=1, o_done=1, o_busy=0.
REQ-032 Ramp: ant0 target 32'h7F00_0100 from reset, step 0x0080 -> I goes 7FFF to 7F7F to 7F00 and Q goes 0000 to 0080 to 0100 over 2 frame heads; o_done after the 2nd.
REQ-033 Negative crossing: act ant5 I=+0x0010, target I=-0x0010 (0xFFF0), step 0x0018 -> I=0xFFF8 after the 1st frame head, 0xFFF0 after the 2nd.
REQ-034 Write while busy: commit, then i_cfg_wr to ant1 in ARMED -> o_wr_drop pulses, tgt[1] unchanged, applied value is the pre-commit target.
REQ-035 Simultaneous commit and frame head in IDLE -> no change that cycle; apply at the next frame head; a commit in RAMP is ignored and step_q is unchanged.
REQ-036 asy_rst asserted after the 1st of 3 ramp frames -> all outputs 32'h7FFF_0000, state IDLE, no o_done.
